rr_mux41: RTL and testbench
===========================

// Module: rr_mux41
// PURPOSE
//  - Gathering end of the 1x4 demux path: merges four valid/ready input channels onto one output channel.
//  - Tags each output word with the 2-bit source select, so a downstream demux14-style stage can route it back out.
//  - Round-robin arbitration: no channel starves.
//  - Registered output stage; one word per cycle sustained throughput.
// PARAMETERS
//  WIDTH  8  data bits per channel
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous reset, active-high
//  in_valid   in   4        per-channel valid, bit k = channel k
//  in_data    in   4*WIDTH  channel k data at [k*WIDTH +: WIDTH]
//  in_ready   out  4        per-channel ready, one-hot or zero
//  out_valid  out  1        output word valid
//  out_data   out  WIDTH    output word
//  out_sel    out  2        source channel of out_data (0..3)
//  out_ready  in   1        downstream accepts the word
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge):
//    - out_valid=0, out_data=0, out_sel=2'b00.
//    - Priority pointer ptr=0.
//    - in_ready forced to 4'b0000 while rst=1.
//  - Load enable: load = !out_valid | out_ready.
//    - The output register may take a new word when it is empty or being drained this cycle.
//  - Arbitration (combinational, only when load=1):
//    - Scan order is ptr, ptr+1, ptr+2, ptr+3, modulo 4.
//    - The first channel with in_valid=1 is granted as g.
//    - in_ready[g]=1; all other in_ready bits are 0.
//    - No requester or load=0: in_ready=0.
//    - in_ready may depend combinationally on in_valid and out_ready.
//  - Transfer: channel k transfers when in_valid[k] & in_ready[k] at a clk edge. At that edge:
//    - out_data <= in_data[k].
//    - out_sel <= k.
//    - out_valid <= 1.
//    - ptr <= (k+1) mod 4; wraps 3 -> 0.
//  - Drain: out_valid & out_ready with no transfer in the same cycle -> out_valid <= 0.
//    - out_data and out_sel hold their last values.
//  - Simultaneous drain and transfer: the new word replaces the old one; out_valid stays 1. Zero bubbles.
//  - Stall: out_valid & !out_ready -> out_data, out_sel and out_valid are held stable; all in_ready=0.
//  - Latency: input transfer to out_valid is 1 cycle.
//  - Throughput: 1 word/cycle while out_ready=1.
//  - ptr changes only on a transfer. Idle cycles and stalls do not move it.
//  - Input contract: an input holding valid without a grant must keep its data stable.
//    - The block does not drop or duplicate words.
//  - Reset mid-operation:
//    - Any word held in the output register is discarded; out_valid=0 on the next cycle.
//    - Pending inputs are not accepted during reset.
//    - Arbitration restarts from channel 0.
// TESTING
//  - Reset: drive rst=1 for 2 cycles with in_valid=4'hF.
//    -> in_ready=0, out_valid=0, out_data=0, out_sel=0.
//    - First grant after reset is channel 0.
//  - Single channel: in_valid=4'b0100, data2=8'hA5, out_ready=1.
//    -> in_ready=4'b0100.
//    - Next cycle: out_valid=1, out_data=8'hA5, out_sel=2.
//  - Round-robin: all four valid continuously, out_ready=1.
//    -> out_sel sequence 0,1,2,3,0,1,... with one word every cycle and no gaps.
//  - Backpressure: out_ready=0 for 3 cycles while a word is held.
//    -> out_data/out_sel are unchanged and in_ready=0.
//    - On release, the next channel in pointer order is granted.
//  - Wrap and skip: ptr=3 and in_valid=4'b0010 -> channel 1 is granted; ptr becomes 2.
//    - Then in_valid=4'b1001 -> channel 3 is granted; ptr becomes 0.
//  - Reset mid-stream: assert rst while out_valid=1 and out_ready=0.
//    -> out_valid=0 the next cycle; the held word never appears.
//    - A scoreboard confirms no duplicated words.

Source files
------------

// File: rtl/rr_mux41_if.sv
// rr_mux41_if: valid/ready bundle for the 4-to-1 round-robin merge
//   in_valid/in_data/in_ready : four source channels, channel k data at [k*WIDTH +: WIDTH]
//   out_valid/out_data/out_sel/out_ready : merged output word tagged with its source channel
//   master drives the sources and the output ready; slave is the merge block itself
interface rr_mux41_if #(parameter int WIDTH = 8);
  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_ready;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_sel);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_sel);
endinterface

// File: rtl/rr_mux41.sv
// rr_mux41: merges four valid/ready channels into one registered output, round-robin, tagged with source
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : rr_mux41_if.slave (four input channels in, one tagged output channel out)
module rr_mux41 #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  rr_mux41_if.slave bus
);
  logic [1:0]       r_ptr;
  logic [1:0]       r_sel;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_load;
  logic             w_any;
  logic             w_xfer;
  logic [1:0]       w_g;
  assign w_load = !r_valid || bus.out_ready;
  // scan from the farthest offset down so the requester closest to r_ptr wins
  always_comb begin
    w_any = 1'b0;
    w_g = r_ptr;
    for (int i = 3; i >= 0; i--)
      if (bus.in_valid[r_ptr + 2'(i)]) begin
        w_any = 1'b1;
        w_g = r_ptr + 2'(i);
      end
  end
  assign w_xfer = !rst && w_load && w_any;
  assign bus.in_ready = w_xfer ? 4'b0001 << w_g : 4'b0000;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 2'd0;
      r_sel <= 2'd0;
      r_valid <= 1'b0;
      r_data <= '0;
    end else if (w_xfer) begin
      r_data <= bus.in_data[32'(w_g) * WIDTH +: WIDTH];
      r_sel <= w_g;
      r_valid <= 1'b1;
      r_ptr <= w_g + 2'd1;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign bus.out_valid = r_valid;
  assign bus.out_data = r_data;
  assign bus.out_sel = r_sel;
endmodule

// File: tb/tb_rr_mux41.sv
// tb_rr_mux41: directed vectors with a scoreboard queue checked by an independent output monitor
module tb_rr_mux41;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] d [4];
  logic [9:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;
  rr_mux41_if #(.WIDTH(8)) bus ();
  rr_mux41 #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  task automatic drive(input logic [3:0] v, input logic ordy);
    bus.in_valid = v;
    bus.in_data = {d[3], d[2], d[1], d[0]};
    bus.out_ready = ordy;
    #1;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // monitor: a word is consumed when out_valid & out_ready just before an edge
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_word: got sel=%0d data=%0h expected none", bus.out_sel, bus.out_data);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({bus.out_sel, bus.out_data} !== e) begin
          n_bad++;
          $display("FAIL word: got sel=%0d data=%0h expected sel=%0d data=%0h", bus.out_sel, bus.out_data, e[9:8], e[7:0]);
        end
      end
    end
  end
  initial begin
    for (int k = 0; k < 4; k++) d[k] = 8'h10 + 8'(k);
    drive(4'hF, 1'b1);
    step();
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_out_sel", 32'(bus.out_sel), 32'h0);
    rst = 1'b0;
    // round robin from ptr=0, all channels requesting
    for (int i = 0; i < 8; i++) begin
      logic [1:0] g;
      g = 2'(i);
      drive(4'hF, 1'b1);
      chk("rr_grant", 32'(bus.in_ready), 32'(4'b0001 << g));
      exp_q.push_back({g, d[g]});
      step();
      chk("rr_valid", 32'(bus.out_valid), 32'h1);
      chk("rr_sel", 32'(bus.out_sel), 32'(g));
      d[g] = d[g] + 8'h40;
    end
    drive(4'h0, 1'b1);
    chk("idle_ready", 32'(bus.in_ready), 32'h0);
    step();
    // single channel 2, ptr=0 -> 3
    d[2] = 8'hA5;
    drive(4'b0100, 1'b1);
    chk("single_grant", 32'(bus.in_ready), 32'b0100);
    exp_q.push_back({2'd2, 8'hA5});
    step();
    chk("single_valid", 32'(bus.out_valid), 32'h1);
    chk("single_data", 32'(bus.out_data), 32'hA5);
    chk("single_sel", 32'(bus.out_sel), 32'h2);
    d[2] = 8'h5A;
    // backpressure for 3 cycles with all requesting
    for (int i = 0; i < 3; i++) begin
      drive(4'hF, 1'b0);
      chk("stall_ready", 32'(bus.in_ready), 32'h0);
      step();
      chk("stall_valid", 32'(bus.out_valid), 32'h1);
      chk("stall_data", 32'(bus.out_data), 32'hA5);
      chk("stall_sel", 32'(bus.out_sel), 32'h2);
    end
    // release: ptr=3 -> channel 3, ptr becomes 0
    drive(4'hF, 1'b1);
    chk("release_grant", 32'(bus.in_ready), 32'b1000);
    exp_q.push_back({2'd3, d[3]});
    step();
    d[3] = d[3] + 8'h40;
    // bring ptr to 3 via channel 2
    drive(4'b0100, 1'b1);
    chk("to_ptr3_grant", 32'(bus.in_ready), 32'b0100);
    exp_q.push_back({2'd2, d[2]});
    step();
    d[2] = d[2] + 8'h40;
    // wrap and skip: ptr=3, only channel 1 -> granted, ptr=2
    drive(4'b0010, 1'b1);
    chk("wrap_grant", 32'(bus.in_ready), 32'b0010);
    exp_q.push_back({2'd1, d[1]});
    step();
    d[1] = d[1] + 8'h40;
    // ptr=2, channels 0 and 3 -> 3 wins, ptr=0
    drive(4'b1001, 1'b1);
    chk("skip_grant", 32'(bus.in_ready), 32'b1000);
    exp_q.push_back({2'd3, d[3]});
    step();
    d[3] = d[3] + 8'h40;
    drive(4'hF, 1'b1);
    chk("ptr0_grant", 32'(bus.in_ready), 32'b0001);
    exp_q.push_back({2'd0, d[0]});
    step();
    d[0] = d[0] + 8'h40;
    // reset while a word is held under backpressure: that word is discarded
    rst = 1'b1;
    drive(4'hF, 1'b0);
    chk("midrst_ready", 32'(bus.in_ready), 32'h0);
    void'(exp_q.pop_back());
    step();
    chk("midrst_valid", 32'(bus.out_valid), 32'h0);
    rst = 1'b0;
    drive(4'hF, 1'b1);
    chk("post_rst_grant", 32'(bus.in_ready), 32'b0001);
    exp_q.push_back({2'd0, d[0]});
    step();
    drive(4'h0, 1'b1);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    step();
    chk("final_idle", 32'(bus.out_valid), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
